// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed or unsigned, W-bit operands to a 2W-bit product.
// Signed operands are reduced to magnitudes and the product sign is restored in FIX.
module seq_multiplier #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p,
  output logic           busy,
  output logic           done
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           s;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;

  // Negating the most negative value yields 2^(W-1), which fits as a W-bit unsigned magnitude.
  always_comb begin
    mag_a = (sgn && a[W-1]) ? (~a + 1'b1) : a;
    mag_b = (sgn && b[W-1]) ? (~b + 1'b1) : b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      s      <= 1'b0;
      p      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{W{1'b0}}, mag_a};
            mplier <= mag_b;
            s      <= sgn & (a[W-1] ^ b[W-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          p     <= s ? (~acc + 1'b1) : acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: three instances (W=3, 8, 4) sharing clock and reset.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start3 = 0, sgn3 = 0, busy3, done3;
  logic [2:0] a3 = 0, b3 = 0;
  logic [5:0] p3;
  logic       start8 = 0, sgn8 = 0, busy8, done8;
  logic [7:0] a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic       start4 = 0, sgn4 = 0, busy4, done4;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] p4;

  seq_multiplier #(.W(3)) u3 (.clk(clk), .rst(rst), .start(start3), .sgn(sgn3), .a(a3), .b(b3),
                              .p(p3), .busy(busy3), .done(done3));
  seq_multiplier #(.W(8)) u8 (.clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
                              .p(p8), .busy(busy8), .done(done8));
  seq_multiplier #(.W(4)) u4 (.clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
                              .p(p4), .busy(busy4), .done(done4));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          inst;
    bit          sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input bit st, input bit sg, input logic [31:0] aa,
                       input logic [31:0] bb);
    case (inst)
      3: begin start3 = st; sgn3 = sg; a3 = aa[2:0]; b3 = bb[2:0]; end
      8: begin start8 = st; sgn8 = sg; a8 = aa[7:0]; b8 = bb[7:0]; end
      default: begin start4 = st; sgn4 = sg; a4 = aa[3:0]; b4 = bb[3:0]; end
    endcase
  endtask

  function automatic logic [63:0] get_p(input int inst);
    case (inst)
      3: return 64'(p3);
      8: return 64'(p8);
      default: return 64'(p4);
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      3: return busy3;
      8: return busy8;
      default: return busy4;
    endcase
  endfunction

  function automatic logic get_done(input int inst);
    case (inst)
      3: return done3;
      8: return done8;
      default: return done4;
    endcase
  endfunction

  // Start one operation (start held for one edge), then wait for done.
  // lat = edges from the start-sampling edge to the one that raises done; -1 on timeout.
  task automatic do_op(input int inst, input bit sg, input logic [31:0] aa, input logic [31:0] bb,
                       output logic [63:0] pr, output int lat, output int busy_n);
    drive(inst, 1'b1, sg, aa, bb);
    step();
    drive(inst, 1'b0, sg, 32'd0, 32'd0);
    busy_n = get_busy(inst) ? 1 : 0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (get_done(inst)) begin
        lat = n;
        break;
      end
      if (get_busy(inst)) busy_n++;
    end
    pr = get_p(inst);
  endtask

  vec_t        vecs[9];
  logic [63:0] pr;
  int          lat, busy_n, dn;

  initial begin
    vecs[0] = '{3, 1'b0, 32'd7,    32'd7,    64'd49};
    vecs[1] = '{8, 1'b1, 32'h80,   32'h80,   64'h4000};
    vecs[2] = '{8, 1'b1, 32'hFF,   32'h01,   64'hFFFF};
    vecs[3] = '{8, 1'b1, 32'h05,   32'hFD,   64'hFFF1};
    vecs[4] = '{8, 1'b0, 32'hFF,   32'hFF,   64'hFE01};
    vecs[5] = '{4, 1'b0, 32'd15,   32'd15,   64'd225};
    vecs[6] = '{4, 1'b1, 32'h8,    32'h7,    64'hC8};
    vecs[7] = '{3, 1'b1, 32'b100,  32'b100,  64'd16};
    vecs[8] = '{3, 1'b1, 32'b011,  32'b110,  64'h3A};

    #12;
    chk("reset_p3", 64'(p3), 64'd0);
    chk("reset_busy_done", {61'd0, busy3 | busy8 | busy4, done3 | done8, done4}, 64'd0);
    chk("reset_p8_p4", {48'd0, p8 | 16'(p4)}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      do_op(vecs[i].inst, vecs[i].sg, vecs[i].a, vecs[i].b, pr, lat, busy_n);
      chk($sformatf("vec%0d_p", i), pr, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].inst + 1));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(vecs[i].inst + 1));
      step();
      chk($sformatf("vec%0d_done_once", i), 64'(get_done(vecs[i].inst)), 64'd0);
    end

    // W=3 exhaustive, back-to-back: each next start is presented in the done cycle.
    drive(3, 1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 64; i++) begin
      step();
      chk("b2b_busy_after_start", {62'd0, busy3, done3}, 64'b10);
      if (i < 63) drive(3, 1'b1, 1'b0, 32'((i + 1) >> 3), 32'((i + 1) & 7));
      else        drive(3, 1'b0, 1'b0, 32'd0, 32'd0);
      start3 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
        step();
        if (done3) begin lat = n; break; end
      end
      chk($sformatf("b2b_%0dx%0d_lat", i >> 3, i & 7), 64'(lat), 64'd4);
      chk($sformatf("b2b_%0dx%0d_p", i >> 3, i & 7), 64'(p3), 64'((i >> 3) * (i & 7)));
      if (i < 63) start3 = 1'b1;
    end
    step();
    chk("b2b_tail_done", 64'(done3), 64'd0);

    // Start re-pulsed during RUN must be ignored.
    drive(8, 1'b1, 1'b0, 32'd10, 32'd10);
    step();
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    drive(8, 1'b1, 1'b0, 32'd3, 32'd3);
    step();
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    dn = 0;
    for (int n = 0; n < 25; n++) begin
      step();
      if (done8) dn++;
    end
    chk("repulse_p", 64'(p8), 64'd100);
    chk("repulse_done_count", 64'(dn), 64'd1);
    chk("repulse_idle_busy", 64'(busy8), 64'd0);

    // Reset in the 4th RUN cycle aborts the operation.
    drive(8, 1'b1, 1'b0, 32'd5, 32'd6);
    step();
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_p", 64'(p8), 64'd0);
    #1;
    rst = 1'b0;
    do_op(8, 1'b0, 32'd2, 32'd9, pr, lat, busy_n);
    chk("after_abort_p", pr, 64'd18);
    chk("after_abort_lat", 64'(lat), 64'd9);

    // Nonzero result held through idle cycles, then a zero operand takes full latency.
    do_op(4, 1'b0, 32'd13, 32'd11, pr, lat, busy_n);
    chk("w4_13x11_p", pr, 64'd143);
    dn = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (p4 !== 8'd143 || done4) dn++;
    end
    chk("w4_hold_nonzero", 64'(dn), 64'd0);
    do_op(4, 1'b0, 32'd0, 32'd15, pr, lat, busy_n);
    chk("w4_zero_p", pr, 64'd0);
    chk("w4_zero_lat", 64'(lat), 64'd5);
    dn = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (p4 !== 8'd0 || done4 || busy4) dn++;
    end
    chk("w4_hold_zero", 64'(dn), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter W, default 3: operand width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; sampled on clk edges.
REQ-005 The block SHALL have port sgn, input, 1 bit: 0 = unsigned operands, 1 = two's-complement operands; sampled with start.
REQ-006 The block SHALL have port a, input, W bits: multiplicand; sampled with start.
REQ-007 The block SHALL have port b, input, W bits: multiplier; sampled with start.
REQ-008 The block SHALL have port p, output, 2W bits: product, registered; holds the last result until the next result is written.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking p as newly valid.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and FIX.
REQ-012 In IDLE, start=1 at edge k SHALL capture a, b and sgn, clear the accumulator, load bit counter = 0, and enter RUN.
- If sgn=1, the block SHALL store operand magnitudes plus sign flag s = a[W-1] XOR b[W-1].
- If sgn=0, s SHALL be 0 and operands SHALL be used as-is.
REQ-013 In RUN, each edge SHALL perform one shift-add step:
- if the current multiplier LSB is 1, add the multiplicand (zero-extended to 2W) to the accumulator;
- shift the multiplier right by 1 and the multiplicand left by 1;
- increment the counter.
REQ-014 RUN SHALL last exactly W edges (k+1..k+W); when counter = W-1 at an edge, the next state SHALL be FIX.
REQ-015 At edge k+W+1 (FIX), p SHALL be written with the accumulator, two's-complement negated if s=1, and the state SHALL return to IDLE.
REQ-016 Total latency SHALL be W+1 cycles from the start-sampling edge to the edge that writes p.
REQ-017 busy SHALL be 1 in RUN and FIX, and 0 in IDLE.
REQ-018 done SHALL be 1 for exactly the one cycle following the FIX edge, and 0 otherwise.
REQ-019 start SHALL be ignored while busy=1; operands and mode SHALL NOT change mid-operation.
REQ-020 start=1 in the cycle where done=1 SHALL be accepted (state is IDLE), giving back-to-back operations with a throughput of one result per W+2 cycles.
REQ-021 Arithmetic SHALL be exact over the full 2W-bit range with no overflow.
- Unsigned maximum: (2^W-1)^2.
- Signed: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) SHALL be representable, handled by using W-bit unsigned magnitudes.
REQ-022 A zero operand SHALL still take the full W+1 cycles; there SHALL be no early termination.
REQ-023 p SHALL NOT change except at the FIX edge or on reset.

Reset
REQ-024 On rst=1, asynchronously: state SHALL go to IDLE, and p, busy, done, the accumulator, operand registers and the counter SHALL all clear to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation: no done pulse and p = 0.
REQ-026 After rst deasserts, the first start SHALL be accepted at the first rising edge of clk.

Verification
REQ-027 A bench SHALL cover these directed scenarios:
- W=3, sgn=0, a=7, b=7, start one cycle -> busy high 4 cycles, done pulse at edge k+4, p=49 (6'b110001).
- W=3, sgn=0, exhaustive 64 pairs back-to-back (start in each done cycle) -> every p equals a*b; no lost or duplicated done.
- W=8, sgn=1: a=0x80, b=0x80 -> p=0x4000; a=0xFF, b=0x01 -> p=0xFFFF; a=0x05, b=0xFD -> p=0xFFF1.
- W=8, start re-pulsed with a=3, b=3 during RUN of 10*10 -> p=100, exactly one done pulse.
- W=8, rst asserted at cycle 4 of RUN -> busy, done and p go to 0 immediately; next start with a=2, b=9 -> p=18.
- W=4, a=0, b=15 -> done still at edge k+5, p=0; p then held through 10 idle cycles.
